rr_encoder: RTL and testbench



---
 rtl/rr_pkg.sv | 21 ++
 rtl/rr_encoder_pick.sv | 39 +++
 rtl/rr_encoder.sv | 104 ++++++++++
 tb/tb_rr_encoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// ============================================================================
// Module   : rr_pkg
// Purpose  : Shared types and constants for the rr_encoder return path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rr_pkg;

    localparam int NUM_REQ = 8;

    typedef logic [2:0] idx_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_encoder_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational cyclic priority search starting at a pointer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import rr_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  idx_t               start,
    input  logic [NUM_REQ-1:0] mask,
    output logic               found,
    output idx_t               idx
);

    logic [NUM_REQ-1:0] w_elig;

    assign w_elig = req & ~mask;

    // First eligible line at or after start, wrapping through 7 back to 0.
    always_comb begin
        idx_t v_pos;
        found = 1'b0;
        idx   = '0;
        v_pos = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_pos = start + idx_t'(k);
            if (!found && w_elig[v_pos]) begin
                found = 1'b1;
                idx   = v_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_encoder.sv
// ============================================================================
// Module   : rr_encoder
// Purpose  : 8-to-3 request encoder with round-robin/fixed arbitration,
//            ready/valid handoff and one-hot grant return.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_encoder
    import rr_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int PTR_INIT   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic ready,
    output logic a,
    output logic b,
    output logic c,
    output logic e,
    output logic g0,
    output logic g1,
    output logic g2,
    output logic g3,
    output logic g4,
    output logic g5,
    output logic g6,
    output logic g7
);

    localparam idx_t c_ptr_init = idx_t'(PTR_INIT);
    localparam bit   c_fixed    = (FIXED_PRIO != 0);

    state_t             r_state;
    idx_t               r_idx;
    idx_t               r_ptr;

    logic [NUM_REQ-1:0] w_req;
    logic               w_xfer;
    idx_t               w_next_ptr;
    idx_t               w_start;
    logic [NUM_REQ-1:0] w_mask;
    logic               w_found;
    idx_t               w_pick;
    logic [NUM_REQ-1:0] w_grant;

    assign w_req      = {d7, d6, d5, d4, d3, d2, d1, d0};
    assign w_xfer     = (r_state == HOLD) && ready;
    assign w_next_ptr = r_idx + 3'd1;

    // On a transfer the search already uses the post-transfer pointer and
    // skips the line just served, so a slow-dropping requester is not re-won.
    assign w_start = c_fixed ? idx_t'(0) : (w_xfer ? w_next_ptr : r_ptr);
    assign w_mask  = w_xfer ? (NUM_REQ'(1) << r_idx) : '0;

    rr_pick u_pick (
        .req   (w_req),
        .start (w_start),
        .mask  (w_mask),
        .found (w_found),
        .idx   (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_ptr   <= c_ptr_init;
        end else if (r_state == IDLE) begin
            if (w_found) begin
                r_idx   <= w_pick;
                r_state <= HOLD;
            end
        end else if (ready) begin
            if (!c_fixed) begin
                r_ptr <= w_next_ptr;
            end
            if (w_found) begin
                r_idx <= w_pick;
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign e       = (r_state == HOLD);
    assign a       = r_idx[2];
    assign b       = r_idx[1];
    assign c       = r_idx[0];
    assign w_grant = e ? (NUM_REQ'(1) << r_idx) : '0;
    assign {g7, g6, g5, g4, g3, g2, g1, g0} = w_grant;

endmodule

`default_nettype wire

// File: tb/tb_rr_encoder.sv
// ============================================================================
// Module   : tb_rr_encoder
// Purpose  : Self-checking bench: round-robin, fixed-priority and offset-pointer
//            instances against a behavioural arbitration model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_encoder;

    localparam int NI = 3;   // 0: RR ptr0, 1: fixed, 2: RR ptr5

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] d = 8'h00;

    logic [NI-1:0][2:0] abc;
    logic [NI-1:0]      ev;
    logic [NI-1:0][7:0] gv;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int m_busy [NI];
    int m_idx  [NI];
    int m_ptr  [NI];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        rr_encoder #(
            .FIXED_PRIO ((i == 1) ? 1 : 0),
            .PTR_INIT   ((i == 2) ? 5 : 0)
        ) u_dut (
            .clk(clk), .rst(rst),
            .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
            .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
            .ready(ready),
            .a(abc[i][2]), .b(abc[i][1]), .c(abc[i][0]), .e(ev[i]),
            .g0(gv[i][0]), .g1(gv[i][1]), .g2(gv[i][2]), .g3(gv[i][3]),
            .g4(gv[i][4]), .g5(gv[i][5]), .g6(gv[i][6]), .g7(gv[i][7])
        );
    end

    function automatic bit is_fixed(int i);
        return i == 1;
    endfunction

    function automatic int ptr_init(int i);
        return (i == 2) ? 5 : 0;
    endfunction

    // First high line in cyclic order from start, skipping excl (-1 = none).
    function automatic int winner(logic [7:0] req, int start, int excl);
        for (int k = 0; k < 8; k++) begin
            int n;
            n = (start + k) % 8;
            if (req[n] && n != excl) return n;
        end
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 0; m_idx[i] = 0; m_ptr[i] = ptr_init(i);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int w;
            int served;
            if (rst) begin
                m_busy[i] = 0; m_idx[i] = 0; m_ptr[i] = ptr_init(i);
            end else if (m_busy[i] == 0) begin
                w = winner(d, is_fixed(i) ? 0 : m_ptr[i], -1);
                if (w >= 0) begin m_busy[i] = 1; m_idx[i] = w; end
            end else if (ready) begin
                served = m_idx[i];
                if (!is_fixed(i)) m_ptr[i] = (served + 1) % 8;
                w = winner(d, is_fixed(i) ? 0 : m_ptr[i], served);
                if (w >= 0) m_idx[i] = w;
                else m_busy[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("e[%0d]", i), int'(ev[i]), m_busy[i]);
                chk($sformatf("g[%0d]", i), int'(gv[i]),
                    (m_busy[i] != 0) ? (1 << m_idx[i]) : 0);
                if (m_busy[i] != 0)
                    chk($sformatf("abc[%0d]", i), int'(abc[i]), m_idx[i]);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset held with d3 high.
        rst = 1'b1; d = 8'h08; ready = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        chk("rst_e", int'(ev[0]), 0);
        chk("rst_abc", int'(abc[0]), 0);
        chk("rst_g", int'(gv[0]), 0);
        rst = 1'b0;
        cyc(1);
        chk("rel_e", int'(ev[0]), 1);
        chk("rel_abc", int'(abc[0]), 3);
        chk("rel_g", int'(gv[0]), 8'h08);
        chk("rel_model", m_idx[0], 3);
        ready = 1'b1; d = 8'h00;
        cyc(1);

        // Hold stability: grant 5 stays while ready low despite input changes.
        d = 8'h20; ready = 1'b0;
        cyc(2);
        d = 8'h04;
        cyc(2);
        chk("hold_abc", int'(abc[0]), 5);
        chk("hold_g", int'(gv[0]), 8'h20);
        ready = 1'b1;
        cyc(1);
        chk("hold_next", int'(abc[0]), 2);
        d = 8'h00;
        cyc(1);

        // Rotation from a freshly reset pointer.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0; d = 8'hFF; ready = 1'b1;
        cyc(1);
        chk("rot_0", int'(abc[0]), 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("rot_%0d", k), int'(abc[0]), k % 8);
            chk($sformatf("rot_model_%0d", k), m_idx[0], k % 8);
        end
        d = 8'h00;
        cyc(1);

        // Wrap and fairness: grant 6, then 7 and 1 compete.
        d = 8'h40;
        cyc(1);
        chk("wrap_6", int'(abc[0]), 6);
        d = 8'h82;
        cyc(1);
        chk("wrap_7", int'(abc[0]), 7);
        cyc(1);
        chk("wrap_1", int'(abc[0]), 1);
        cyc(1);
        chk("wrap_7b", int'(abc[0]), 7);
        d = 8'h00;
        cyc(2);

        // Reset mid-hold drops the pending index.
        d = 8'h10; ready = 1'b0;
        cyc(1);
        chk("mid_abc", int'(abc[0]), 4);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_e", int'(ev[0]), 0);
        rst = 1'b0;
        cyc(1);
        chk("mid_rel_e", int'(ev[0]), 1);
        chk("mid_rel_abc", int'(abc[0]), 4);
        ready = 1'b1; d = 8'h00;
        cyc(2);

        // Fixed priority with d2 and d6: the served line sits out one edge.
        d = 8'h44;
        cyc(1);
        chk("fx_2", int'(abc[1]), 2);
        cyc(1);
        chk("fx_6", int'(abc[1]), 6);
        cyc(1);
        chk("fx_2b", int'(abc[1]), 2);
        d = 8'h40;
        cyc(1);
        chk("fx_6b", int'(abc[1]), 6);
        d = 8'h00;
        cyc(2);

        // Randomised traffic; occasional reset.
        for (int t = 0; t < 3000; t++) begin
            d     = 8'($urandom) & 8'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
